// File: rtl/lut_equation_writer.sv
// lut_equation_writer: runtime programmer for RAM-backed 4-input LUTs.
//
// A request (16-bit truth table plus LUT index) is accepted over a valid/ready
// handshake. The 16 truth-table bits are then written serially into the
// selected LUT, one address per cycle, with address 0 first.
//
// Ports:
//   clock, reset              sole clock; synchronous active-high reset
//   req_valid / req_ready     request handshake
//   req_lut_sel, req_equation request fields, sampled only at the handshake
//   lut_we                    one-hot write enable into the LUT bank
//   lut_addr, lut_din         shared address (A3..A0 = x,y,u,v) and data
//   busy                      high while a write sequence runs
//   done, err                 one-cycle completion pulse; err flags an
//                             out-of-range index
// Every output comes straight from a flop.
module lut_equation_writer #(
  parameter int unsigned NUM_LUTS = 16,
  parameter int unsigned SEL_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SEL_W-1:0]    req_lut_sel,
  input  logic [15:0]         req_equation,
  output logic [NUM_LUTS-1:0] lut_we,
  output logic [3:0]          lut_addr,
  output logic                lut_din,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [15:0]         eq_q, eq_d;
  logic [NUM_LUTS-1:0] we_q, we_d;
  logic                din_q, din_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [3:0]          cnt_inc;

  // An index outside the bank matches no bit, so the enable stays all-zero.
  function automatic logic [NUM_LUTS-1:0] decode(input logic [SEL_W-1:0] sel);
    logic [NUM_LUTS-1:0] dec;
    dec = '0;
    for (int unsigned i = 0; i < NUM_LUTS; i++) begin
      dec[i] = (32'(sel) == i);
    end
    return dec;
  endfunction

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    eq_d    = eq_q;
    we_d    = '0;
    din_d   = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          state_d = StWrite;
          cnt_d   = 4'd0;
          sel_d   = req_lut_sel;
          eq_d    = req_equation;
          // Present address 0 in the first write cycle.
          we_d    = decode(req_lut_sel);
          din_d   = req_equation[0];
          ready_d = 1'b0;
        end
      end
      StWrite: begin
        if (cnt_q == 4'd15) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
          ready_d = 1'b1;
          done_d  = 1'b1;
          err_d   = (32'(sel_q) >= NUM_LUTS);
        end else begin
          cnt_d = cnt_inc;
          we_d  = decode(sel_q);
          din_d = eq_q[cnt_inc];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      sel_q   <= '0;
      eq_q    <= 16'h0;
      we_q    <= '0;
      din_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      eq_q    <= eq_d;
      we_q    <= we_d;
      din_q   <= din_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign lut_we    = we_q;
  assign lut_addr  = cnt_q;
  assign lut_din   = din_q;
  assign busy      = (state_q == StWrite);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/lut_equation_writer.md
# lut_equation_writer

Runtime programmer for RAM-backed 4-input LUT primitives (RAM64X1S-style, A4/A5 tied low). It accepts a 16-bit truth-table equation plus a target LUT index over a valid/ready handshake, then serially writes the 16 entries into the selected LUT, one bit per cycle. It sits between the configuration/instruction path and a bank of `NUM_LUTS` LUT instances, and is the write side of the read-only LUT wrappers. Once programmed, each LUT evaluates `equation >> {x,y,u,v}`.

## Interface
- `NUM_LUTS`, 16, number of LUT instances driven (1..64)
- `SEL_W`, 4, width of the LUT select field; must satisfy 2^SEL_W >= NUM_LUTS
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  writer can accept a request
- `req_lut_sel`  in  SEL_W  target LUT index
- `req_equation`  in  16  truth table; bit k = output for {x,y,u,v} = k
- `lut_we`  out  NUM_LUTS  one-hot write enable, bit i drives LUT i's WE
- `lut_addr`  out  4  shared address to A3..A0 (A3=x, A2=y, A1=u, A0=v)
- `lut_din`  out  1  shared write data to D
- `busy`  out  1  high while a write sequence is in progress
- `done`  out  1  one-cycle pulse when a sequence completes
- `err`  out  1  qualifies `done`: target index was >= NUM_LUTS

## Operation
- States: IDLE, WRITE. No other states.
- IDLE: `req_ready`=1. When `req_valid & req_ready`, latch `req_lut_sel` and `req_equation`, clear the counter, and go to WRITE.
- WRITE: 4-bit counter k runs 0..15. Each cycle: `lut_addr`=k, `lut_din`=equation[k], `lut_we`=one-hot(sel). If sel >= NUM_LUTS, `lut_we`=0 throughout and the sequence still runs 16 cycles. At k=15, return to IDLE.
- On entry to IDLE from WRITE: `done`=1 for exactly one cycle, and `err`=1 in that same cycle iff sel was out of range. Otherwise `err`=0.
- `req_ready`=0 and `busy`=1 for the whole WRITE state. Requests presented during WRITE are not sampled and not queued.
- Request fields are sampled only at the handshake. Later changes to the inputs have no effect.
- All outputs are registered. Nothing in the module is combinational from inputs to outputs.
- No counter wrap-around is visible: the counter is forced to 0 on each accept.

## Timing
- Reset value of every output is 0: `req_ready`, `lut_we`, `lut_addr`, `lut_din`, `busy`, `done`, `err`.
- `req_ready` rises the first cycle after `reset` deasserts.
- Handshake in cycle T: write cycles are T+1..T+16, with `lut_addr` 0..15 in order. The LUT captures each bit on the edge that ends the cycle.
- Cycle T+17: state IDLE, `done` pulse (and `err` if applicable), `req_ready`=1. A request accepted at T+17 starts writing at T+18, giving a throughput of 17 cycles per equation.
- `busy` equals "state == WRITE" and is high exactly during T+1..T+16.
- Reset mid-sequence: on the next edge the state returns to IDLE and all outputs return to 0, with no `done`. The target LUT keeps the bits already written; higher addresses retain their old contents.
- Reset asserted together with a handshake: the request is dropped.

## Test plan
- Reset for 3 cycles, then release -> all outputs 0 during reset; `req_ready`=1 one cycle after release; `lut_we` never asserted.
- Send sel=3, eq=16'h8000 at T -> `lut_we`=16'h0008 for T+1..T+16, `lut_din`=0 for addr 0..14 and 1 at addr 15. `done`=1, `err`=0 at T+17. A behavioural LUT model then outputs 1 only for x=y=u=v=1.
- Back-to-back: sel=0 eq=16'hFFFF, then sel=15 eq=16'h6996 with `req_valid` held -> second accept at T+17, `lut_we`=16'h8000 for T+18..T+33. LUT 15 then computes XOR parity and LUT 0 is all ones.
- With NUM_LUTS=12, SEL_W=4, send sel=13, eq=16'hAAAA -> `lut_we`=0 for all 16 cycles; `done`=1 with `err`=1 at T+17.
- Assert `reset` at write cycle k=5 of sel=2, eq=16'hFFFF over a LUT preloaded with 16'h0000 -> `lut_we`=0 from the next cycle, no `done`. LUT 2 holds 16'h003F.
- During WRITE, toggle `req_valid` and change `req_equation`/`req_lut_sel` every cycle -> `req_ready` stays 0, the written data matches the originally latched request, and no extra sequence starts.
